fault_latch_monitor: RTL and testbench
======================================

Name: fault_latch_monitor

Overview:
- Parametrised multi-channel fault monitor for the drive's protection path.
- Synchronises and debounces N hardware fault lines, then latches each fault sticky until software clear.
- Freezes a status snapshot for a fixed hold window so the display/comm layer can read a stable value.
- Records which channel(s) faulted first and counts fault events; fault_any feeds the PWM-inhibit logic.

Parameters:
- N_CH, 8, number of fault channels (1..32)
- ACTIVE_LOW, 1, 1: fault_in bit = 0 means fault; 0: bit = 1 means fault
- FILTER, 3, consecutive samples required to change filtered state (>=1)
- HOLD_CYCLES, 20_000_000, snapshot freeze length in clk cycles (>=2)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- fault_in  in  N_CH  raw asynchronous fault lines, polarity per ACTIVE_LOW
- mask  in  N_CH  1 = channel excluded from latching/trigger/fault_any (synchronous to clk)
- clear  in  1  synchronous single-cycle clear of latched state
- fault_live  out  N_CH  filtered fault state, active-high
- fault_latched  out  N_CH  sticky unmasked faults, active-high
- first_fault  out  N_CH  unmasked channels whose fault triggered the first HOLD since clear
- snapshot  out  N_CH  fault_live in IDLE, frozen during HOLD
- fault_any  out  1  OR of fault_latched
- hold_active  out  1  high while in HOLD
- evt_count  out  8  saturating count of trigger events

Behaviour:
- Reset (reset=0, async): all outputs 0, FSM=IDLE, hold counter 0, filter counters 0. Synchroniser flops and filter state reset to the no-fault level.
- Input path: 2-FF synchroniser per channel, converted to active-high.
- Filter per channel: filtered state flips only after FILTER consecutive synchronised samples of the opposite level. Any disagreeing sample resets the run count.
- Latency: a stable raw fault is visible on fault_live 2+FILTER edges after first sampled. Deassertion follows the same latency.
- Trigger: trig = OR(fault_live & ~mask & ~prev), where prev = (fault_live & ~mask) registered. Unmasking an active fault therefore triggers.
- Latching, one edge after trig:
  - fault_latched |= fault_live & ~mask.
  - A channel that becomes unmasked while live latches on that edge.
  - Masking a channel does not clear its latched bit.
- FSM IDLE:
  - snapshot <= fault_live every cycle.
  - On trig: go to HOLD, snapshot <= fault_live, counter <= 0.
  - If first_fault == 0, first_fault <= fault_live & ~mask & ~prev.
- FSM HOLD:
  - snapshot frozen; counter increments each cycle; hold_active=1.
  - When counter == HOLD_CYCLES-1: return to IDLE next edge. HOLD lasts exactly HOLD_CYCLES cycles.
  - Triggers during HOLD latch bits and increment evt_count, but do not restart the counter or change snapshot or first_fault.
- evt_count: +1 per trig cycle (IDLE or HOLD), saturates at 255.
- clear: zeroes fault_latched, first_fault and evt_count. Does not affect FSM, snapshot or fault_live.
  - If trig coincides with clear, set wins: new bits latch, evt_count = 1, and first_fault is loaded if in IDLE.
  - A fault still live but with no new edge is not re-latched by clear.
- fault_any = OR(fault_latched), registered with fault_latched (no extra cycle).
- Counter width: $clog2(HOLD_CYCLES). No wrap possible.
- reset asserted mid-HOLD: immediate return to the reset state.

Test Plan:
- Reset, ACTIVE_LOW=1, fault_in=8'hFF, FILTER=3 → all outputs 0. Drive bit2 low → fault_live=8'h04 on edge 5, fault_latched=8'h04 and fault_any=1 on edge 6, hold_active=1, first_fault=8'h04, evt_count=1.
- Glitch: bit0 low for 2 cycles then high → fault_live, fault_latched and evt_count unchanged.
- HOLD_CYCLES=10: trigger bit1, then bit5 four cycles later → snapshot stays 8'h02, fault_latched=8'h22, first_fault=8'h02, evt_count=2. hold_active high exactly 10 cycles, then snapshot tracks live.
- mask=8'h08 with bit3 faulted → fault_live=8'h08, fault_latched=0, no HOLD. Drop mask → latch 8'h08 and HOLD entered.
- clear pulse in the same cycle as a new bit4 trigger → fault_latched=8'h10, evt_count=1, first_fault=8'h10 if IDLE.
- 300 separate fault pulses → evt_count saturates at 255. Assert reset mid-HOLD → all outputs 0 immediately.

Source files
------------

// File: rtl/fault_latch_monitor_if.sv
// fault_latch_monitor_if: fault inputs, software controls and latched status of the fault monitor.
interface fault_latch_monitor_if #(
    parameter int N_CH = 8
);
    logic [N_CH-1:0] fault_in;
    logic [N_CH-1:0] mask;
    logic            clear;
    logic [N_CH-1:0] fault_live;
    logic [N_CH-1:0] fault_latched;
    logic [N_CH-1:0] first_fault;
    logic [N_CH-1:0] snapshot;
    logic            fault_any;
    logic            hold_active;
    logic [7:0]      evt_count;

    modport master (
        output fault_in, mask, clear,
        input  fault_live, fault_latched, first_fault, snapshot, fault_any, hold_active, evt_count
    );

    modport slave (
        input  fault_in, mask, clear,
        output fault_live, fault_latched, first_fault, snapshot, fault_any, hold_active, evt_count
    );
endinterface

// File: rtl/fault_latch_monitor.sv
// fault_latch_monitor: synchronises, debounces and latches N fault lines; freezes a status snapshot while in HOLD.
module fault_latch_monitor #(
    parameter int N_CH        = 8,
    parameter int ACTIVE_LOW  = 1,
    parameter int FILTER      = 3,
    parameter int HOLD_CYCLES = 20_000_000
) (
    input logic                  clk,
    input logic                  reset,
    fault_latch_monitor_if.slave bus
);
    localparam int FCW = $clog2(FILTER + 1);
    localparam int HCW = $clog2(HOLD_CYCLES);
    localparam logic [N_CH-1:0] RAW_OK = {N_CH{ACTIVE_LOW != 0}};

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t          r_state, w_state_nxt;
    logic [N_CH-1:0] r_sync1, r_sync2, r_live, r_prev, r_latched, r_first, r_snap;
    logic [FCW-1:0]  r_fcnt [N_CH];
    logic [HCW-1:0]  r_hcnt;
    logic [7:0]      r_evt;
    logic            r_any;
    logic [N_CH-1:0] w_sync_ah, w_act, w_new, w_lat_base, w_lat_nxt, w_first_base, w_first_nxt;
    logic [7:0]      w_evt_base, w_evt_nxt;
    logic            w_trig, w_hold_done, w_hold_active;

    assign w_sync_ah    = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;
    assign w_act        = r_live & ~bus.mask;
    assign w_new        = w_act & ~r_prev;
    assign w_trig       = |w_new;
    assign w_hold_done  = r_hcnt == HCW'(HOLD_CYCLES - 1);
    // Clear is applied first so a coinciding trigger still sets (set wins).
    assign w_lat_base   = bus.clear ? '0 : r_latched;
    assign w_lat_nxt    = w_lat_base | (w_trig ? w_act : '0);
    assign w_first_base = bus.clear ? '0 : r_first;
    assign w_first_nxt  = (r_state == S_IDLE && w_trig && w_first_base == '0) ? w_new : w_first_base;
    assign w_evt_base   = bus.clear ? 8'd0 : r_evt;
    assign w_evt_nxt    = (w_trig && w_evt_base != 8'hFF) ? w_evt_base + 8'd1 : w_evt_base;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= RAW_OK;
            r_sync2 <= RAW_OK;
            r_live  <= '0;
            for (int c = 0; c < N_CH; c++) r_fcnt[c] <= '0;
        end else begin
            r_sync1 <= bus.fault_in;
            r_sync2 <= r_sync1;
            // Each channel flips only after FILTER consecutive disagreeing samples.
            for (int c = 0; c < N_CH; c++) begin
                if (w_sync_ah[c] == r_live[c]) begin
                    r_fcnt[c] <= '0;
                end else if (r_fcnt[c] == FCW'(FILTER - 1)) begin
                    r_fcnt[c] <= '0;
                    r_live[c] <= ~r_live[c];
                end else begin
                    r_fcnt[c] <= r_fcnt[c] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev    <= '0;
            r_latched <= '0;
            r_first   <= '0;
            r_evt     <= '0;
            r_any     <= 1'b0;
        end else begin
            r_prev    <= w_act;
            r_latched <= w_lat_nxt;
            r_first   <= w_first_nxt;
            r_evt     <= w_evt_nxt;
            r_any     <= |w_lat_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_hcnt  <= '0;
            r_snap  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hcnt  <= (r_state == S_HOLD) ? r_hcnt + 1'b1 : '0;
            r_snap  <= (r_state == S_IDLE) ? r_live : r_snap;
        end
    end

    always_comb begin
        w_state_nxt = (r_state == S_IDLE) ? (w_trig ? S_HOLD : S_IDLE) : (w_hold_done ? S_IDLE : S_HOLD);
    end

    always_comb begin
        w_hold_active = r_state == S_HOLD;
    end

    assign bus.fault_live    = r_live;
    assign bus.fault_latched = r_latched;
    assign bus.first_fault   = r_first;
    assign bus.snapshot      = r_snap;
    assign bus.fault_any     = r_any;
    assign bus.hold_active   = w_hold_active;
    assign bus.evt_count     = r_evt;
endmodule

// File: tb/tb_fault_latch_monitor.sv
// tb_fault_latch_monitor: directed scenarios; expectations queued at stimulus time, popped at sample time.
module tb_fault_latch_monitor;
    localparam int N  = 8;
    localparam int HC = 10;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fault_latch_monitor_if #(.N_CH(N)) bus ();

    fault_latch_monitor #(
        .N_CH(N), .ACTIVE_LOW(1), .FILTER(3), .HOLD_CYCLES(HC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string t, input logic [31:0] v);
        exp_t e;
        e.tag = t;
        e.val = v;
        q.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.val)
            else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic all_zero(input string t);
        push({t, "_live"}, 0);
        push({t, "_latched"}, 0);
        push({t, "_first"}, 0);
        push({t, "_snap"}, 0);
        push({t, "_any"}, 0);
        push({t, "_hold"}, 0);
        push({t, "_evt"}, 0);
        chk(bus.fault_live);
        chk(bus.fault_latched);
        chk(bus.first_fault);
        chk(bus.snapshot);
        chk(bus.fault_any);
        chk(bus.hold_active);
        chk(bus.evt_count);
    endtask

    task automatic clear_pulse();
        bus.clear = 1'b1;
        step(1);
        bus.clear = 1'b0;
    endtask

    initial begin
        bus.fault_in = '1;
        bus.mask     = '0;
        bus.clear    = 1'b0;
        step(3);
        all_zero("reset");
        reset = 1'b1;
        step(2);

        // Basic latency and latch
        bus.fault_in[2] = 1'b0;
        step(4);
        push("live_edge4", 0); chk(bus.fault_live);
        step(1);
        push("live_edge5", 8'h04);    chk(bus.fault_live);
        push("latched_edge5", 0);     chk(bus.fault_latched);
        step(1);
        push("latched_edge6", 8'h04); push("any_edge6", 1); push("hold_edge6", 1);
        push("first_edge6", 8'h04);   push("evt_edge6", 1); push("snap_edge6", 8'h04);
        chk(bus.fault_latched); chk(bus.fault_any); chk(bus.hold_active);
        chk(bus.first_fault);   chk(bus.evt_count); chk(bus.snapshot);
        bus.fault_in = '1;
        step(20);
        push("sticky_latched", 8'h04); push("sticky_hold", 0); push("sticky_evt", 1);
        chk(bus.fault_latched); chk(bus.hold_active); chk(bus.evt_count);
        clear_pulse();
        push("clr_latched", 0); push("clr_first", 0); push("clr_evt", 0); push("clr_any", 0);
        chk(bus.fault_latched); chk(bus.first_fault); chk(bus.evt_count); chk(bus.fault_any);

        // Two-sample glitch is filtered out
        bus.fault_in[0] = 1'b0;
        step(2);
        bus.fault_in[0] = 1'b1;
        step(8);
        push("glitch_live", 0); push("glitch_latched", 0); push("glitch_evt", 0);
        chk(bus.fault_live); chk(bus.fault_latched); chk(bus.evt_count);

        // Second fault during HOLD
        bus.fault_in[1] = 1'b0;
        step(4);
        bus.fault_in[5] = 1'b0;
        step(2);
        push("h_hold_in", 1); push("h_snap_in", 8'h02); push("h_latched_in", 8'h02);
        push("h_first_in", 8'h02); push("h_evt_in", 1);
        chk(bus.hold_active); chk(bus.snapshot); chk(bus.fault_latched);
        chk(bus.first_fault); chk(bus.evt_count);
        step(4);
        push("h2_live", 8'h22); push("h2_latched", 8'h22); push("h2_evt", 2);
        push("h2_snap", 8'h02); push("h2_first", 8'h02);
        chk(bus.fault_live); chk(bus.fault_latched); chk(bus.evt_count);
        chk(bus.snapshot); chk(bus.first_fault);
        step(5);
        push("h_hold_last", 1); push("h_snap_last", 8'h02);
        chk(bus.hold_active); chk(bus.snapshot);
        step(1);
        push("h_hold_end", 0); chk(bus.hold_active);
        step(1);
        push("h_snap_track", 8'h22); chk(bus.snapshot);
        bus.fault_in = '1;
        step(10);
        clear_pulse();
        push("h_clr_latched", 0); chk(bus.fault_latched);

        // Masked fault, then unmask
        bus.mask        = 8'h08;
        bus.fault_in[3] = 1'b0;
        step(8);
        push("m_live", 8'h08); push("m_latched", 0); push("m_hold", 0); push("m_evt", 0);
        chk(bus.fault_live); chk(bus.fault_latched); chk(bus.hold_active); chk(bus.evt_count);
        bus.mask = '0;
        step(1);
        push("um_latched", 8'h08); push("um_hold", 1); push("um_evt", 1);
        push("um_first", 8'h08);   push("um_any", 1);
        chk(bus.fault_latched); chk(bus.hold_active); chk(bus.evt_count);
        chk(bus.first_fault);   chk(bus.fault_any);
        bus.fault_in = '1;
        step(15);
        push("um_hold_end", 0); chk(bus.hold_active);

        // Clear coinciding with a new trigger: set wins
        bus.fault_in[4] = 1'b0;
        step(5);
        push("cs_live", 8'h10); push("cs_latched_pre", 8'h08);
        chk(bus.fault_live); chk(bus.fault_latched);
        clear_pulse();
        push("cs_latched", 8'h10); push("cs_evt", 1); push("cs_first", 8'h10); push("cs_hold", 1);
        chk(bus.fault_latched); chk(bus.evt_count); chk(bus.first_fault); chk(bus.hold_active);
        bus.fault_in = '1;
        step(20);
        clear_pulse();

        // Event counter saturation
        for (int i = 0; i < 300; i++) begin
            bus.fault_in[6] = 1'b0;
            step(5);
            bus.fault_in[6] = 1'b1;
            step(5);
            if (i == 99) begin
                push("sat_evt_100", 100);
                chk(bus.evt_count);
            end
        end
        step(5);
        push("sat_evt_255", 8'hFF); push("sat_latched", 8'h40);
        chk(bus.evt_count); chk(bus.fault_latched);

        // Asynchronous reset in the middle of HOLD
        bus.fault_in[6] = 1'b0;
        step(7);
        push("rst_hold_pre", 1); chk(bus.hold_active);
        reset = 1'b0;
        #1;
        all_zero("midhold_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
